// File: rtl/fb_pixel_loader.sv
// Frame-buffer fill stage: packs an R,G,B byte stream into 24-bit words and writes them linearly.
// Optional running byte checksum is built only when FB_LOADER_CHECKSUM_EN is defined.
module fb_pixel_loader #(
    parameter int BRAM_WIDTH     = 24,
    parameter int BRAM_ADDR_BITS = 20,
    parameter int HDISPLAY       = 1024,
    parameter int VDISPLAY       = 768
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      ram_enable,
    output logic                      write_enable,
    output logic [BRAM_ADDR_BITS-1:0] address,
    output logic [BRAM_WIDTH-1:0]     input_data,
    output logic                      busy,
    output logic                      frame_done,
    output logic [7:0]                checksum
);

    localparam int TOTAL = HDISPLAY * VDISPLAY;
    localparam logic [BRAM_ADDR_BITS-1:0] LAST_PIX = BRAM_ADDR_BITS'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                    state;
    logic [BRAM_ADDR_BITS-1:0] pix_cnt;
    logic [1:0]                byte_idx;
    logic [15:0]               pix_rg;
    logic                      xfer;

    assign xfer = s_valid && s_ready;

    // Scan-out reads R in the low byte, B in the high byte.
    function automatic logic [BRAM_WIDTH-1:0] pack_rgb(input logic [7:0] b,
                                                       input logic [15:0] rg);
        return BRAM_WIDTH'({b, rg});
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            ram_enable   <= 1'b0;
            write_enable <= 1'b0;
            address      <= '0;
            input_data   <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            pix_cnt      <= '0;
            byte_idx     <= '0;
            pix_rg       <= '0;
        end else begin
            ram_enable   <= 1'b0;
            write_enable <= 1'b0;
            frame_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        s_ready  <= 1'b1;
                        busy     <= 1'b1;
                        pix_cnt  <= '0;
                        byte_idx <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        unique case (byte_idx)
                            2'd0: begin
                                pix_rg[7:0] <= s_data;
                                byte_idx    <= 2'd1;
                            end
                            2'd1: begin
                                pix_rg[15:8] <= s_data;
                                byte_idx     <= 2'd2;
                            end
                            default: begin
                                // Third byte goes straight into the write word.
                                byte_idx     <= '0;
                                s_ready      <= 1'b0;
                                ram_enable   <= 1'b1;
                                write_enable <= 1'b1;
                                address      <= pix_cnt;
                                input_data   <= pack_rgb(s_data, pix_rg);
                                state        <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (pix_cnt == LAST_PIX) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                        s_ready <= 1'b1;
                        state   <= LOAD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FB_LOADER_CHECKSUM_EN
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= 8'h00;
        end else if (state == IDLE && start) begin
            checksum <= 8'h00;
        end else if (xfer) begin
            checksum <= csum_add(checksum, s_data);
        end
    end
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_fb_pixel_loader.sv
// Directed bench for fb_pixel_loader on a 4x2 frame: table-driven pixels plus reset/abort/checksum sequences.
module tb_fb_pixel_loader;

    localparam int AW = 20;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          ram_enable;
    logic          write_enable;
    logic [AW-1:0] address;
    logic [DW-1:0] input_data;
    logic          busy;
    logic          frame_done;
    logic [7:0]    checksum;

    fb_pixel_loader #(
        .BRAM_WIDTH(DW), .BRAM_ADDR_BITS(AW), .HDISPLAY(4), .VDISPLAY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .ram_enable(ram_enable), .write_enable(write_enable),
        .address(address), .input_data(input_data), .busy(busy),
        .frame_done(frame_done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [23:0] word;
    } pix_vec_t;

    pix_vec_t vecs[8];
    int total_cnt = 0;
    int pass_cnt  = 0;

    // Write/frame_done monitor
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            wr_cyc[$];
    int            cyc = 0;
    int            fd_cnt = 0;
    int            fd_cyc = 0;
    int            overlap_cnt = 0;
    int            held_cnt = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (write_enable) begin
            wr_addr.push_back(address);
            wr_data.push_back(input_data);
            wr_cyc.push_back(cyc);
        end
        if (write_enable && s_ready) overlap_cnt <= overlap_cnt + 1;
        if (write_enable && s_valid) held_cnt <= held_cnt + 1;
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("s_ready_timeout", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_pixels(input int first, input int last, input int maxgap);
        for (int p = first; p <= last; p++) begin
            send_byte(vecs[p].r, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
            send_byte(vecs[p].g, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
            send_byte(vecs[p].b, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!frame_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
        chk("busy_during_done", {31'd0, busy}, 32'd1);
        chk("we_during_done", {31'd0, write_enable}, 32'd0);
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("frame_done_pulse", {31'd0, frame_done}, 32'd0);
    endtask

    task automatic check_frame(input int base, input int fd_before, input logic use_table,
                               input logic [23:0] const_word);
        logic [23:0] exp_w;
        chk("write_count", 32'(wr_addr.size() - base), 32'd8);
        chk("frame_done_count", 32'(fd_cnt - fd_before), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (base + i < wr_addr.size()) begin
                exp_w = use_table ? vecs[i].word : const_word;
                chk($sformatf("addr[%0d]", i), 32'(wr_addr[base+i]), 32'(i));
                chk($sformatf("data[%0d]", i), 32'(wr_data[base+i]), 32'(exp_w));
            end
        end
        if (base + 7 < wr_cyc.size())
            chk("done_latency", 32'(fd_cyc - wr_cyc[base+7]), 32'd1);
    endtask

    initial begin
        int base;
        int fdb;
        logic [7:0] tbl_sum;
        logic [7:0] exp_sum;

        vecs[0] = '{8'h11, 8'h22, 8'h33, 24'h332211};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 24'h000000};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
        vecs[3] = '{8'h01, 8'h02, 8'h03, 24'h030201};
        vecs[4] = '{8'hA5, 8'h5A, 8'hC3, 24'hC35AA5};
        vecs[5] = '{8'h80, 8'h00, 8'h7F, 24'h7F0080};
        vecs[6] = '{8'h12, 8'h34, 8'h56, 24'h563412};
        vecs[7] = '{8'hFE, 8'hDC, 8'hBA, 24'hBADCFE};
        tbl_sum = 8'h00;
        for (int i = 0; i < 8; i++) tbl_sum = tbl_sum + vecs[i].r + vecs[i].g + vecs[i].b;

        // T1: reset with start and s_valid asserted
        rst_n = 1'b0; start = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_ram_enable", {31'd0, ram_enable}, 32'd0);
        chk("rst_write_enable", {31'd0, write_enable}, 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_input_data", 32'(input_data), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        chk("rst_no_writes", 32'(wr_addr.size()), 32'd0);
        rst_n = 1'b1; start = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", {31'd0, s_ready}, 32'd0);

        // T2 + T3: first pixel back-to-back, rest with random gaps
        base = wr_addr.size(); fdb = fd_cnt;
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_s_ready", {31'd0, s_ready}, 32'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        s_valid = 1'b0;
        chk("t2_we", {31'd0, write_enable}, 32'd1);
        chk("t2_en", {31'd0, ram_enable}, 32'd1);
        chk("t2_addr", 32'(address), 32'd0);
        chk("t2_data", 32'(input_data), 32'h332211);
        chk("t2_ready_in_write", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        chk("t2_we_one_cycle", {31'd0, write_enable}, 32'd0);
        chk("t2_back_to_load", {31'd0, s_ready}, 32'd1);
        send_pixels(1, 7, 3);
        wait_done();
        check_frame(base, fdb, 1'b1, 24'h0);
`ifdef FB_LOADER_CHECKSUM_EN
        exp_sum = tbl_sum;
`else
        exp_sum = 8'h00;
`endif
        chk("table_checksum", 32'(checksum), 32'(exp_sum));

        // T4: continuous s_valid, bytes held across WRITE cycles
        repeat (2) @(negedge clk);
        base = wr_addr.size(); fdb = fd_cnt;
        pulse_start();
        chk("checksum_cleared", 32'(checksum), 32'd0);
        send_pixels(0, 7, 0);
        wait_done();
        check_frame(base, fdb, 1'b1, 24'h0);
        chk("ready_in_write", 32'(overlap_cnt), 32'd0);
        chk("valid_held_in_write", 32'(held_cnt > 0), 32'd1);

        // T5: abort after 2 bytes of pixel 3
        base = wr_addr.size();
        pulse_start();
        send_pixels(0, 2, 1);
        send_byte(vecs[3].r, 0);
        send_byte(vecs[3].g, 0);
        s_valid = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_s_ready", {31'd0, s_ready}, 32'd0);
        chk("abort_we", {31'd0, write_enable}, 32'd0);
        @(negedge clk);
        s_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("abort_writes", 32'(wr_addr.size() - base), 32'd3);
        base = wr_addr.size(); fdb = fd_cnt;
        pulse_start();
        send_pixels(0, 7, 2);
        wait_done();
        check_frame(base, fdb, 1'b1, 24'h0);

        // T6: constant bytes, checksum, start while busy ignored
        base = wr_addr.size(); fdb = fd_cnt;
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(8'h10, 0);
        s_valid = 1'b0;
        pulse_start();
        chk("busy_after_ignored_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 12; i++) send_byte(8'h10, $urandom_range(0, 1));
        s_valid = 1'b0;
        wait_done();
        check_frame(base, fdb, 1'b0, 24'h101010);
`ifdef FB_LOADER_CHECKSUM_EN
        exp_sum = 8'h80;
`else
        exp_sum = 8'h00;
`endif
        chk("t6_checksum", 32'(checksum), 32'(exp_sum));
        repeat (4) @(negedge clk);
        chk("t6_checksum_hold", 32'(checksum), 32'(exp_sum));
        chk("idle_no_extra_writes", 32'(wr_addr.size() - base), 32'd8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
